// File: rtl/vertex_screen_mapper.sv
// vertex_screen_mapper
//   Maps one clip-space vertex (x, y, z, w) to screen pixel coordinates and a
//   Q1.O_ZBITS depth. The vertex is first tested against the clip volume. A
//   rejected vertex is returned at once, flagged invalid. An accepted vertex
//   has 1/w computed once by an iterative restoring divider. That reciprocal
//   scales x, y and z, and the results are mapped to the clamped screen range.
//
// Ports
//   clk             clock
//   rstn            asynchronous active-low reset
//   i_vertex[4]     signed clip x, y, z, w (I_FRACBITS fractional bits)
//   i_tag           user tag, returned unchanged on o_tag
//   i_valid         input vertex valid
//   i_ready         high iff the block is idle and can take a vertex
//   o_vertex_pixel  screen x, y (clamped to the screen, signed O_DATAWIDTH)
//   o_vertex_z      ndc z, signed Q1.O_ZBITS
//   o_clip_code     outcode: b0 x<-w b1 x>w b2 y<-w b3 y>w b4 z<-w b5 z>w b6 w<W_MIN
//   o_invalid       vertex rejected; pixel and z are 0
//   o_tag           tag of the output vertex
//   o_valid         output valid, held with all outputs until i_ready_out
//   i_ready_out     downstream ready
module vertex_screen_mapper #(
  parameter int I_DATAWIDTH   = 24,
  parameter int I_FRACBITS    = 13,
  parameter int O_DATAWIDTH   = 10,
  parameter int O_ZBITS       = 11,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int W_MIN         = 1 << (I_FRACBITS - 3),
  parameter int TAG_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic signed [I_DATAWIDTH-1:0] i_vertex [4],
  input  logic [TAG_WIDTH-1:0]          i_tag,
  input  logic                          i_valid,
  output logic                          i_ready,
  output logic signed [O_DATAWIDTH-1:0] o_vertex_pixel [2],
  output logic signed [O_ZBITS:0]       o_vertex_z,
  output logic [6:0]                    o_clip_code,
  output logic                          o_invalid,
  output logic [TAG_WIDTH-1:0]          o_tag,
  output logic                          o_valid,
  input  logic                          i_ready_out
);

  localparam int DW    = I_DATAWIDTH;
  localparam int F     = I_FRACBITS;
  localparam int EW    = DW + 1;
  localparam int PW    = 2 * DW;
  localparam int CNT_W = $clog2(DW);

  // 2^(2F) is wider than the DW quotient bits the divider walks through.
  // The bits above DW therefore preload the partial remainder. This is
  // safe because they are far smaller than any accepted w.
  localparam logic [DW-1:0]        REM_INIT = DW'(1 << (2 * F - DW));
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DW - 1);
  localparam logic signed [DW-1:0] W_MIN_S  = DW'(W_MIN);
  localparam logic signed [PW-1:0] ONE      = PW'(2 ** F);
  localparam logic signed [PW-1:0] SW       = PW'(SCREEN_WIDTH);
  localparam logic signed [PW-1:0] SH       = PW'(SCREEN_HEIGHT);
  localparam logic signed [PW-1:0] SX_MAX   = PW'(SCREEN_WIDTH - 1);
  localparam logic signed [PW-1:0] SY_MAX   = PW'(SCREEN_HEIGHT - 1);
  localparam logic signed [O_ZBITS:0] Z_MAX = {1'b0, {O_ZBITS{1'b1}}};
  localparam logic signed [O_ZBITS:0] Z_MIN = {1'b1, {O_ZBITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIP,   // outcode evaluated and registered
    S_CHECK,  // reject now, or arm the divider
    S_RECIP,  // one quotient bit per cycle
    S_PROJ,   // scale, map and clamp
    S_OUT     // hold results until downstream takes them
  } state_t;

  state_t                  state_q, state_d;
  logic signed [DW-1:0]    vtx_q [4];
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [6:0]              code_q, code_d;
  logic [DW-1:0]           rem_q, quo_q;
  logic [CNT_W-1:0]        cnt_q;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments. Every register
  // then updates from the values it had before the edge, regardless of
  // the order in which the blocks run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the next-state default is assigned before the case statement.
  // Every path then drives state_d, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_valid) state_d = S_CLIP;
      S_CLIP:  state_d = S_CHECK;
      S_CHECK: state_d = (code_q != '0) ? S_OUT : S_RECIP;
      S_RECIP: if (cnt_q == CNT_LAST) state_d = S_PROJ;
      S_PROJ:  state_d = S_OUT;
      S_OUT:   if (i_ready_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign i_ready = (state_q == S_IDLE);

  // -------------------------------------------------------- clip outcode
  // The compare uses one extra bit, so negating the most negative w cannot wrap.
  logic signed [EW-1:0] ex, ey, ez, ew, nw;

  always_comb begin
    ex = EW'(vtx_q[0]);
    ey = EW'(vtx_q[1]);
    ez = EW'(vtx_q[2]);
    ew = EW'(vtx_q[3]);
    nw = -ew;
    code_d    = '0;
    code_d[0] = ex < nw;
    code_d[1] = ex > ew;
    code_d[2] = ey < nw;
    code_d[3] = ey > ew;
    code_d[4] = ez < nw;
    code_d[5] = ez > ew;
    code_d[6] = vtx_q[3] < W_MIN_S;
  end

  // ---------------------------------------------------- restoring divide
  // Each cycle shifts in the next dividend bit, which is always 0 below
  // REM_INIT. The shifted remainder is compared against w, which is known
  // to be positive here.
  logic [DW:0]   rem_sh;
  logic          rem_ge;
  logic [DW-1:0] rem_nxt;

  always_comb begin
    rem_sh  = {rem_q, 1'b0};
    rem_ge  = rem_sh >= {1'b0, vtx_q[3]};
    rem_nxt = rem_ge ? DW'(rem_sh - {1'b0, vtx_q[3]}) : rem_sh[DW-1:0];
  end

  // ---------------------------------------------------------- projection
  logic signed [PW-1:0]          recip_w, ndc_x, ndc_y, ndc_z, sx_full, sy_full;
  logic signed [O_DATAWIDTH-1:0] px_d, py_d;
  logic signed [O_ZBITS:0]       z_d;

  always_comb begin
    recip_w = $signed({{(PW - DW){1'b0}}, quo_q});
    // |c| <= w, so each product stays far below 2^(PW-1).
    ndc_x   = (PW'(vtx_q[0]) * recip_w) >>> F;
    ndc_y   = (PW'(vtx_q[1]) * recip_w) >>> F;
    ndc_z   = (PW'(vtx_q[2]) * recip_w) >>> F;
    // Screen y grows downward, so ndc y is flipped.
    sx_full = ((ndc_x + ONE) * SW) >>> (F + 1);
    sy_full = ((ONE - ndc_y) * SH) >>> (F + 1);

    if (sx_full < 0)           px_d = '0;
    else if (sx_full > SX_MAX) px_d = SX_MAX[O_DATAWIDTH-1:0];
    else                       px_d = sx_full[O_DATAWIDTH-1:0];

    if (sy_full < 0)           py_d = '0;
    else if (sy_full > SY_MAX) py_d = SY_MAX[O_DATAWIDTH-1:0];
    else                       py_d = sy_full[O_DATAWIDTH-1:0];

    // Q1.O_ZBITS cannot represent +/-1.0 exactly, so the edges saturate.
    if (ndc_z >= ONE)       z_d = Z_MAX;
    else if (ndc_z <= -ONE) z_d = Z_MIN;
    else                    z_d = {ndc_z[PW-1], ndc_z[F-1 -: O_ZBITS]};
  end

  // ------------------------------------------------------------ datapath
  // NOTE: the vertex holding registers are reset along with the control
  // state. They are only four words. Resetting them keeps unknown values
  // out of the combinational clip and projection logic after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vtx_q  <= '{default: '0};
      tag_q  <= '0;
      code_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_valid) begin
          vtx_q <= i_vertex;
          tag_q <= i_tag;
        end
        S_CLIP:  code_q <= code_d;
        S_CHECK: begin
          rem_q <= REM_INIT;
          quo_q <= '0;
          cnt_q <= '0;
        end
        S_RECIP: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[DW-2:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------- outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid        <= 1'b0;
      o_invalid      <= 1'b0;
      o_vertex_pixel <= '{default: '0};
      o_vertex_z     <= '0;
      o_clip_code    <= '0;
      o_tag          <= '0;
    end else if (state_q == S_CHECK && code_q != '0) begin
      o_valid        <= 1'b1;
      o_invalid      <= 1'b1;
      o_vertex_pixel <= '{default: '0};
      o_vertex_z     <= '0;
      o_clip_code    <= code_q;
      o_tag          <= tag_q;
    end else if (state_q == S_PROJ) begin
      o_valid           <= 1'b1;
      o_invalid         <= 1'b0;
      o_vertex_pixel[0] <= px_d;
      o_vertex_pixel[1] <= py_d;
      o_vertex_z        <= z_d;
      o_clip_code       <= code_q;
      o_tag             <= tag_q;
    end else if (state_q == S_OUT && i_ready_out) begin
      o_valid   <= 1'b0;
      o_invalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vertex_screen_mapper.sv
// tb_vertex_screen_mapper
//   Directed testbench for vertex_screen_mapper with default parameters
//   (F = 13, 1.0 = 0x2000). Expected values are hand-computed constants.
module tb_vertex_screen_mapper;

  logic              clk = 1'b0;
  logic              rstn;
  logic signed [23:0] vtx [4];
  logic [7:0]        i_tag;
  logic              i_valid;
  logic              i_ready;
  logic signed [9:0] o_pix [2];
  logic signed [11:0] o_z;
  logic [6:0]        o_code;
  logic              o_invalid;
  logic [7:0]        o_tag;
  logic              o_valid;
  logic              i_ready_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vertex_screen_mapper dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_vertex       (vtx),
    .i_tag          (i_tag),
    .i_valid        (i_valid),
    .i_ready        (i_ready),
    .o_vertex_pixel (o_pix),
    .o_vertex_z     (o_z),
    .o_clip_code    (o_code),
    .o_invalid      (o_invalid),
    .o_tag          (o_tag),
    .o_valid        (o_valid),
    .i_ready_out    (i_ready_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for i_ready and presents one vertex; returns just after edge N.
  task automatic send(input logic signed [23:0] x, y, z, w, input logic [7:0] tag);
    int guard = 0;
    @(negedge clk);
    while (i_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", 32'(i_ready), 1);
    vtx[0] = x; vtx[1] = y; vtx[2] = z; vtx[3] = w;
    i_tag   = tag;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Counts edges until o_valid is seen; the latency is compared with exp_lat.
  task automatic wait_out(input string t, input int exp_lat);
    int lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (o_valid === 1'b1) break;
    end
    check({t, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_out(input string t, input int ex_x, ex_y, ex_z, ex_code,
                           input int ex_inv, ex_tag);
    check({t, "_valid"}, 32'(o_valid), 1);
    check({t, "_px"},    32'({o_pix[0]}), ex_x);
    check({t, "_py"},    32'({o_pix[1]}), ex_y);
    check({t, "_z"},     32'({o_z}), ex_z);
    check({t, "_code"},  32'(o_code), ex_code);
    check({t, "_inv"},   32'(o_invalid), ex_inv);
    check({t, "_tag"},   32'(o_tag), ex_tag);
    check({t, "_busy"},  32'(i_ready), 0);
  endtask

  task automatic release_out(input string t);
    @(negedge clk);
    i_ready_out = 1'b1;
    @(posedge clk);
    #1 i_ready_out = 1'b0;
    @(negedge clk);
    check({t, "_drop"},  32'(o_valid), 0);
    check({t, "_idle"},  32'(i_ready), 1);
    check({t, "_inv0"},  32'(o_invalid), 0);
  endtask

  initial begin
    rstn = 1'b0; i_valid = 1'b0; i_ready_out = 1'b0; i_tag = '0;
    vtx = '{default: '0};
    #3;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ready", 32'(i_ready), 1);
    check("rst_px",    32'({o_pix[0]}), 0);
    check("rst_py",    32'({o_pix[1]}), 0);
    check("rst_z",     32'({o_z}), 0);
    check("rst_code",  32'(o_code), 0);
    check("rst_inv",   32'(o_invalid), 0);
    check("rst_tag",   32'(o_tag), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // Centre of the screen: r = 8192, ndc = 0.
    send(24'sh0, 24'sh0, 24'sh0, 24'sh2000, 8'h11);
    wait_out("center", 27);
    check_out("center", 160, 160, 0, 0, 0, 8'h11);
    release_out("center");

    // Half-way vertex. i_valid pulses with other data while busy and must be ignored.
    // The output is then held for 5 stalled cycles.
    send(24'sh1000, 24'sh1000, 24'sh1000, 24'sh2000, 8'h22);
    vtx[0] = -24'sh1800; vtx[1] = 24'sh0; vtx[2] = 24'sh0; vtx[3] = 24'sh2000;
    i_tag = 8'hEE; i_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_valid = 1'b0;
    wait_out("half", 22);
    check_out("half", 240, 80, 12'h400, 0, 0, 8'h22);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 32'(o_valid), 1);
      check("stall_px",    32'({o_pix[0]}), 240);
      check("stall_tag",   32'(o_tag), 8'h22);
      check("stall_ready", 32'(i_ready), 0);
    end
    release_out("half");

    // x = w edge: ndc_x = 1.0 -> sx = 320 clamps to 319. Downstream is ready early.
    i_ready_out = 1'b1;
    send(24'sh4000, 24'sh0, 24'sh0, 24'sh4000, 8'h33);
    wait_out("xedge", 27);
    check_out("xedge", 319, 160, 0, 0, 0, 8'h33);
    @(posedge clk);
    @(negedge clk);
    check("xedge_drop", 32'(o_valid), 0);
    check("xedge_idle", 32'(i_ready), 1);
    i_ready_out = 1'b0;

    // x > w: rejected, code 0x02.
    send(24'sh3000, 24'sh0, 24'sh0, 24'sh2000, 8'h44);
    wait_out("xrej", 2);
    check_out("xrej", 0, 0, 0, 7'h02, 1, 8'h44);
    release_out("xrej");

    // w below W_MIN: rejected with bit 6. The next vertex must be processed normally.
    send(24'sh0, 24'sh0, 24'sh0, 24'sh0100, 8'h55);
    wait_out("wmin", 2);
    check_out("wmin", 0, 0, 0, 7'h40, 1, 8'h55);
    release_out("wmin");
    send(24'sh0, 24'sh0, 24'sh0, 24'sh2000, 8'h56);
    wait_out("after_rej", 27);
    check_out("after_rej", 160, 160, 0, 0, 0, 8'h56);
    release_out("after_rej");

    // y = -w and z = -w on the boundary: accepted. sy clamps to 319 and z saturates to min.
    send(24'sh0, -24'sh2000, -24'sh2000, 24'sh2000, 8'h66);
    wait_out("yneg", 27);
    check_out("yneg", 160, 319, 12'h800, 0, 0, 8'h66);
    release_out("yneg");

    // z = w: z saturates to max.
    send(24'sh0, 24'sh0, 24'sh2000, 24'sh2000, 8'h67);
    wait_out("zmax", 27);
    check_out("zmax", 160, 160, 12'h7FF, 0, 0, 8'h67);
    release_out("zmax");

    // Negative half-way vertex: sx 80, sy 240, z -0.5 = 0xC00.
    send(-24'sh1000, -24'sh1000, -24'sh1000, 24'sh2000, 8'h68);
    wait_out("neg", 27);
    check_out("neg", 80, 240, 12'hC00, 0, 0, 8'h68);
    release_out("neg");

    // Reset in the middle of the divide clears everything at once.
    send(24'sh1000, 24'sh0, 24'sh0, 24'sh2000, 8'h77);
    repeat (10) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mrst_valid", 32'(o_valid), 0);
    check("mrst_ready", 32'(i_ready), 1);
    check("mrst_px",    32'({o_pix[0]}), 0);
    check("mrst_py",    32'({o_pix[1]}), 0);
    check("mrst_z",     32'({o_z}), 0);
    check("mrst_tag",   32'(o_tag), 0);
    @(negedge clk) rstn = 1'b1;
    send(24'sh0, 24'sh0, 24'sh0, 24'sh2000, 8'h99);
    wait_out("recover", 27);
    check_out("recover", 160, 160, 0, 0, 0, 8'h99);
    release_out("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
